uart_fifo: RTL and testbench

Parametrised UART with an internal baud generator, a transmit FIFO and an optional receiver with its own FIFO. It runs entirely in the `clk` domain with no separate bit clock, and exposes a two-register byte bus (data, status) to the CPU's I/O decode. Frame format is 1 start bit, `DATA_BITS` data bits LSB-first, `STOP_BITS` stop bits, and no parity.

---
 rtl/uart_fifo.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// UART with baud generator, TX FIFO and optional receiver + RX FIFO, all in the clk domain.
// Define UART_FIFO_RX_EN to build the receiver path; otherwise the design is TX-only.

module uart_fifo_buf #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic               push_ok, pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a push while full still lands.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
    end
endmodule

module uart_fifo #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       addr,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       re,
    output logic [7:0] rdata,
    input  logic       rx,
    output logic       tx
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                 tx_push, tx_load, tx_full, tx_empty, tx_idle;
    logic [DATA_BITS-1:0] tx_head, tx_sh;
    state_t               tx_state, tx_state_nxt;
    logic [CW-1:0]        tx_baud;
    logic [BW-1:0]        tx_idx;
    logic                 tx_stop_idx, tx_done, tx_bit_last, tx_stop_last, tx_d;

    logic                 rx_avail, rx_overrun, rx_frame_err;
    logic [DATA_BITS-1:0] rx_head;
    logic                 unused_in;

    assign tx_push = we && !addr;

    uart_fifo_buf #(.DATA_W(DATA_BITS), .FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (tx_push),
        .pop    (tx_load),
        .wdata  (wdata[DATA_BITS-1:0]),
        .head   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    assign tx_done      = (tx_baud == '0);
    assign tx_bit_last  = (tx_idx == IDX_LAST);
    assign tx_stop_last = (STOP_BITS == 1) ? 1'b1 : tx_stop_idx;
    assign tx_idle      = tx_empty && (tx_state == IDLE);

    // tx is registered so reset and state changes never glitch the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx       <= tx_d;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            IDLE:  if (!tx_empty) tx_state_nxt = START;
            START: if (tx_done) tx_state_nxt = DATA;
            DATA:  if (tx_done && tx_bit_last) tx_state_nxt = STOP;
            STOP:  if (tx_done && tx_stop_last) tx_state_nxt = tx_empty ? IDLE : START;
            default: tx_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_load = 1'b0;
        tx_d    = tx;
        case (tx_state)
            IDLE:  if (!tx_empty) begin
                       tx_load = 1'b1;
                       tx_d    = 1'b0;
                   end
            START: if (tx_done) tx_d = tx_sh[0];
            DATA:  if (tx_done) tx_d = tx_bit_last ? 1'b1 : tx_sh[1];
            STOP:  if (tx_done && tx_stop_last && !tx_empty) begin
                       tx_load = 1'b1;
                       tx_d    = 1'b0;
                   end
            default: tx_d = 1'b1;
        endcase
    end

    // Baud counter sits at full reload in IDLE so START always gets a whole bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_baud     <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
        end else begin
            if (tx_state == IDLE || tx_done) tx_baud <= BIT_LAST;
            else                              tx_baud <= tx_baud - 1'b1;
            if (tx_state == START)               tx_idx <= '0;
            else if (tx_state == DATA && tx_done) tx_idx <= tx_idx + 1'b1;
            if (tx_state != STOP)  tx_stop_idx <= 1'b0;
            else if (tx_done)      tx_stop_idx <= ~tx_stop_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_load)                          tx_sh <= tx_head;
        else if (tx_state == DATA && tx_done) tx_sh <= tx_sh >> 1;
    end

`ifdef UART_FIFO_RX_EN
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic                 rx_s1, rx_s2, rx_s3, rx_fall;
    state_t               rx_state, rx_state_nxt;
    logic [CW-1:0]        rx_baud;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_done, rx_push, rx_pop, rx_full, rx_empty;
    logic                 rx_ovr_set, rx_ferr_set, rx_shift, status_rd;

    assign unused_in = ^wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // A start needs a high-to-low edge, so after a framing error the line must rise first.
    assign rx_fall   = rx_s3 && !rx_s2;
    assign rx_done   = (rx_baud == '0);
    assign rx_pop    = re && !addr && !rx_empty;
    assign status_rd = re && addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_state <= IDLE;
        else          rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_state_nxt = START;
            START: if (rx_done) rx_state_nxt = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_done && rx_idx == IDX_LAST) rx_state_nxt = STOP;
            STOP:  if (rx_done) rx_state_nxt = IDLE;
            default: rx_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_shift    = (rx_state == DATA) && rx_done;
        rx_push     = (rx_state == STOP) && rx_done && rx_s2;
        rx_ferr_set = (rx_state == STOP) && rx_done && !rx_s2;
        rx_ovr_set  = rx_push && rx_full && !rx_pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_baud      <= '0;
            rx_idx       <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_state == IDLE) rx_baud <= HALF_LAST;
            else if (rx_done)     rx_baud <= BIT_LAST;
            else                  rx_baud <= rx_baud - 1'b1;
            if (rx_state == START) rx_idx <= '0;
            else if (rx_shift)     rx_idx <= rx_idx + 1'b1;
            if (rx_ovr_set)      rx_overrun <= 1'b1;
            else if (status_rd)  rx_overrun <= 1'b0;
            if (rx_ferr_set)     rx_frame_err <= 1'b1;
            else if (status_rd)  rx_frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_shift) rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
    end

    uart_fifo_buf #(.DATA_W(DATA_BITS), .FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (rx_push),
        .pop    (rx_pop),
        .wdata  (rx_sh),
        .head   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    assign rx_avail = !rx_empty;
`else
    assign unused_in    = ^{rx, re, wdata};
    assign rx_avail     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_head      = '0;
`endif

    always_comb begin
        rdata = '0;
        if (addr)          rdata[4:0] = {rx_frame_err, rx_overrun, rx_avail, tx_idle, tx_full};
        else if (rx_avail) rdata[DATA_BITS-1:0] = rx_head;
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: TX frames decoded by a line monitor and scored against a queue.
// RX scenarios run only when UART_FIFO_RX_EN is defined for the build.

module tb_uart_fifo;
    localparam int CLK_DIV   = 4;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int FIFO_AW   = 2;
    localparam int FRAME     = (1 + DATA_BITS + STOP_BITS) * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       addr = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       rx, tx;
    logic       rx_drv = 1'b1;
    logic       rx_loop = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0]       exp_q[$];
    logic [7:0]       rx_exp_q[$];
    logic [FRAME-1:0] obs_f[$];
    int               obs_c[$];

    assign rx = rx_loop ? tx : rx_drv;

    uart_fifo #(
        .CLK_DIV  (CLK_DIV),
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .re     (re),
        .rdata  (rdata),
        .rx     (rx),
        .tx     (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: records every complete frame sample-by-sample and its start cycle.
    logic [FRAME-1:0] mon_f;
    int               mon_sc;
    bit               mon_abort;
    always begin
        @(negedge clk);
        if (reset_n === 1'b1 && tx === 1'b0) begin
            mon_sc    = cyc;
            mon_abort = 1'b0;
            mon_f     = '0;
            mon_f[0]  = tx;
            for (int i = 1; i < FRAME; i++) begin
                @(negedge clk);
                mon_f[i] = tx;
                if (reset_n !== 1'b1) mon_abort = 1'b1;
            end
            if (!mon_abort) begin
                obs_f.push_back(mon_f);
                obs_c.push_back(mon_sc);
            end
        end
    end

    function automatic logic [FRAME-1:0] exp_frame(input logic [7:0] b);
        logic [FRAME-1:0] f;
        int k;
        for (int i = 0; i < FRAME; i++) begin
            k = i / CLK_DIV;
            if (k == 0)              f[i] = 1'b0;
            else if (k <= DATA_BITS) f[i] = b[k-1];
            else                     f[i] = 1'b1;
        end
        return f;
    endfunction

    task automatic cpu_write(input logic [7:0] d, output int wcyc);
        @(negedge clk);
        addr  = 1'b0;
        wdata = d;
        we    = 1'b1;
        wcyc  = cyc + 1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic peek(input logic a, input logic r, output logic [7:0] v);
        @(negedge clk);
        addr = a;
        re   = r;
        #1 v = rdata;
        @(posedge clk);
        #1 re = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int limit, output bit ok);
        int w;
        w = 0;
        while (obs_f.size() < n && w < limit) begin
            @(negedge clk);
            w++;
        end
        ok = (obs_f.size() >= n);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        reset_n = 1'b1;
        peek(1'b1, 1'b0, v);
        tests++;
        if (v !== 8'h02) begin fails++; $display("FAIL reset_status: got %h want 02", v); end
        peek(1'b0, 1'b1, v);
        tests++;
        if (v !== 8'h00) begin fails++; $display("FAIL reset_data_read: got %h want 00", v); end
    endtask

    task automatic test_basic_frame();
        int wc, sc;
        bit ok;
        logic [7:0] v;
        logic [FRAME-1:0] f, ef;
        exp_q.push_back(8'h55);
        cpu_write(8'h55, wc);
        addr = 1'b1;
        #1;
        tests++;
        if (rdata !== 8'h00) begin fails++; $display("FAIL basic_busy_status: got %h want 00", rdata); end
        wait_frames(1, 4 * FRAME, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_timeout: got 0 frames want 1");
        end else begin
            f  = obs_f.pop_front();
            sc = obs_c.pop_front();
            ef = exp_frame(exp_q.pop_front());
            tests++;
            if (f !== ef) begin fails++; $display("FAIL basic_frame: got %h want %h", f, ef); end
            tests++;
            if (sc !== wc + 1) begin fails++; $display("FAIL basic_latency: got start %0d want %0d", sc, wc + 1); end
        end
        peek(1'b1, 1'b0, v);
        tests++;
        if (v !== 8'h02) begin fails++; $display("FAIL basic_idle_after: got %h want 02", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [6];
        logic [7:0] v;
        logic [FRAME-1:0] f, ef;
        int wc0, sc, prev;
        bit ok;
        d = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hE7};
        for (int i = 0; i < 5; i++) exp_q.push_back(d[i]);
        @(negedge clk);
        addr  = 1'b0;
        we    = 1'b1;
        wdata = d[0];
        wc0   = cyc + 1;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            wdata = d[i];
        end
        @(negedge clk);
        we   = 1'b0;
        addr = 1'b1;
        #1;
        tests++;
        if (rdata !== 8'h01) begin fails++; $display("FAIL fill_full_status: got %h want 01", rdata); end
        wait_frames(5, 6 * FRAME, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL fill_timeout: got %0d frames want 5", obs_f.size());
        end else begin
            prev = 0;
            for (int i = 0; i < 5; i++) begin
                f  = obs_f.pop_front();
                sc = obs_c.pop_front();
                ef = exp_frame(exp_q.pop_front());
                tests++;
                if (f !== ef) begin fails++; $display("FAIL fill_frame%0d: got %h want %h", i, f, ef); end
                tests++;
                if (i == 0 && sc !== wc0 + 1) begin
                    fails++;
                    $display("FAIL fill_latency: got start %0d want %0d", sc, wc0 + 1);
                end else if (i > 0 && sc - prev !== FRAME) begin
                    fails++;
                    $display("FAIL fill_gap%0d: got spacing %0d want %0d", i, sc - prev, FRAME);
                end
                prev = sc;
            end
        end
        repeat (2 * FRAME) @(negedge clk);
        tests++;
        if (obs_f.size() !== 0) begin fails++; $display("FAIL fill_dropped: got %0d extra frames want 0", obs_f.size()); end
        peek(1'b1, 1'b0, v);
        tests++;
        if (v !== 8'h02) begin fails++; $display("FAIL fill_idle_after: got %h want 02", v); end
    endtask

    task automatic test_reset_mid_frame();
        int wc;
        logic [7:0] v;
        cpu_write(8'hA5, wc);
        repeat (2 * CLK_DIV + 2) @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin fails++; $display("FAIL midreset_pre_tx: got %b want 0", tx); end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL midreset_tx: got %b want 1", tx); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        peek(1'b1, 1'b0, v);
        tests++;
        if (v !== 8'h02) begin fails++; $display("FAIL midreset_status: got %h want 02", v); end
        repeat (2 * FRAME) @(negedge clk);
        tests++;
        if (obs_f.size() !== 0) begin fails++; $display("FAIL midreset_frames: got %0d want 0", obs_f.size()); end
    endtask

`ifdef UART_FIFO_RX_EN
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic bitv;
        @(negedge clk);
        for (int k = 0; k < 1 + DATA_BITS + STOP_BITS; k++) begin
            if (k == 0)              bitv = 1'b0;
            else if (k <= DATA_BITS) bitv = b[k-1];
            else                     bitv = stop;
            rx_drv = bitv;
            repeat (CLK_DIV) @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        int wc, w;
        bit ok;
        logic [7:0] s, v, e;
        logic [FRAME-1:0] f, ef;
        rx_loop = 1'b1;
        exp_q.push_back(8'hA3);
        rx_exp_q.push_back(8'hA3);
        cpu_write(8'hA3, wc);
        wait_frames(1, 4 * FRAME, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL loop_tx_timeout: got 0 frames want 1");
        end else begin
            f  = obs_f.pop_front();
            void'(obs_c.pop_front());
            ef = exp_frame(exp_q.pop_front());
            tests++;
            if (f !== ef) begin fails++; $display("FAIL loop_tx_frame: got %h want %h", f, ef); end
        end
        s = 8'h00;
        w = 0;
        while (!s[2] && w < 4 * CLK_DIV) begin
            peek(1'b1, 1'b0, s);
            w++;
        end
        tests++;
        if (s !== 8'h06) begin fails++; $display("FAIL loop_avail: got %h want 06", s); end
        e = rx_exp_q.pop_front();
        peek(1'b0, 1'b1, v);
        tests++;
        if (v !== e) begin fails++; $display("FAIL loop_data: got %h want %h", v, e); end
        peek(1'b1, 1'b0, s);
        tests++;
        if (s[2] !== 1'b0) begin fails++; $display("FAIL loop_avail_clear: got %b want 0", s[2]); end
        rx_loop = 1'b0;
    endtask

    task automatic test_rx_errors();
        logic [7:0] s;
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (FRAME) @(negedge clk);
        peek(1'b1, 1'b0, s);
        tests++;
        if (s !== 8'h02) begin fails++; $display("FAIL glitch_status: got %h want 02", s); end
        send_rx(8'h3C, 1'b0);
        repeat (2 * CLK_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        peek(1'b1, 1'b1, s);
        tests++;
        if (s !== 8'h12) begin fails++; $display("FAIL ferr_status: got %h want 12", s); end
        peek(1'b1, 1'b0, s);
        tests++;
        if (s !== 8'h02) begin fails++; $display("FAIL ferr_clear: got %h want 02", s); end
    endtask

    task automatic test_overrun();
        logic [7:0] d [5];
        logic [7:0] s, v, e;
        d = '{8'h11, 8'hC3, 8'h5A, 8'h7E, 8'h99};
        for (int i = 0; i < 4; i++) rx_exp_q.push_back(d[i]);
        for (int i = 0; i < 5; i++) send_rx(d[i], 1'b1);
        rx_drv = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        peek(1'b1, 1'b0, s);
        tests++;
        if (s !== 8'h0E) begin fails++; $display("FAIL ovr_status: got %h want 0e", s); end
        for (int i = 0; i < 4; i++) begin
            e = rx_exp_q.pop_front();
            peek(1'b0, 1'b1, v);
            tests++;
            if (v !== e) begin fails++; $display("FAIL ovr_data%0d: got %h want %h", i, v, e); end
        end
        peek(1'b1, 1'b1, s);
        tests++;
        if (s !== 8'h0A) begin fails++; $display("FAIL ovr_drained: got %h want 0a", s); end
        peek(1'b1, 1'b0, s);
        tests++;
        if (s !== 8'h02) begin fails++; $display("FAIL ovr_clear: got %h want 02", s); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_FIFO_RX_EN
        test_loopback();
        test_rx_errors();
        test_overrun();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
